// File: rtl/s_axi_burst_read_bridge.sv
// AXI4 read-only slave: queues AR requests, expands each burst into per-beat user
// read requests and returns the user data as in-order R beats.
module s_axi_burst_read_bridge #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AR_DEPTH   = 4,
    parameter int unsigned RSP_DEPTH  = 8
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic [ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [ID_WIDTH-1:0]   S_AXI_RID,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [ADDR_WIDTH-1:0] USR_REQ_ADDR,
    output logic                  USR_REQ_VALID,
    input  logic                  USR_REQ_READY,
    input  logic [DATA_WIDTH-1:0] USR_RSP_DATA,
    input  logic                  USR_RSP_VALID
);

    localparam int unsigned AR_PW = $clog2(AR_DEPTH);
    localparam int unsigned AR_CW = $clog2(AR_DEPTH + 1);
    localparam int unsigned RS_PW = $clog2(RSP_DEPTH);
    localparam int unsigned RS_CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned AR_EW = ID_WIDTH + 8 + 3 + 2 + ADDR_WIDTH;
    localparam int unsigned TAG_W = ID_WIDTH + 1 + 2;
    localparam int unsigned R_EW  = DATA_WIDTH + TAG_W;
    localparam logic [2:0]  MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

    logic [AR_EW-1:0]      ar_mem_q [AR_DEPTH];
    logic [AR_EW-1:0]      ar_mem_d [AR_DEPTH];
    logic [AR_PW-1:0]      ar_wp_q, ar_wp_d, ar_rp_q, ar_rp_d;
    logic [AR_CW-1:0]      ar_cnt_q, ar_cnt_d;

    logic [TAG_W-1:0]      tag_mem_q [RSP_DEPTH];
    logic [TAG_W-1:0]      tag_mem_d [RSP_DEPTH];
    logic [RS_PW-1:0]      tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;

    logic [R_EW-1:0]       r_mem_q [RSP_DEPTH];
    logic [R_EW-1:0]       r_mem_d [RSP_DEPTH];
    logic [RS_PW-1:0]      r_wp_q, r_wp_d, r_rp_q, r_rp_d;
    logic [RS_CW-1:0]      r_cnt_q, r_cnt_d;
    logic [RS_CW-1:0]      outst_q, outst_d;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] incr_q, incr_d;
    logic [ADDR_WIDTH-1:0] mask_q, mask_d;
    logic [7:0]            beats_q, beats_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  err_q, err_d;

    logic [ID_WIDTH-1:0]   h_id;
    logic [7:0]            h_len;
    logic [2:0]            h_size;
    logic [1:0]            h_burst;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [15:0]           h_wrap_bytes;
    logic [ADDR_WIDTH-1:0] h_beat_bytes;
    logic [ADDR_WIDTH-1:0] h_wrap_mask;
    logic                  h_wrap_ok;
    logic [ADDR_WIDTH-1:0] next_addr;

    logic ar_push, ar_pop, req_fire, rsp_fire, r_pop;

    function automatic logic [AR_PW-1:0] ar_ptr_inc(input logic [AR_PW-1:0] p);
        return (p == AR_PW'(AR_DEPTH - 1)) ? '0 : p + AR_PW'(1);
    endfunction

    function automatic logic [RS_PW-1:0] rs_ptr_inc(input logic [RS_PW-1:0] p);
        return (p == RS_PW'(RSP_DEPTH - 1)) ? '0 : p + RS_PW'(1);
    endfunction

    assign S_AXI_ARREADY = (ar_cnt_q != AR_CW'(AR_DEPTH)) && !S_AXI_ARESET;
    assign USR_REQ_VALID = (state_q == ST_ISSUE) && (outst_q != RS_CW'(RSP_DEPTH));
    assign USR_REQ_ADDR  = addr_q;
    assign S_AXI_RVALID  = (r_cnt_q != '0);
    assign {S_AXI_RDATA, S_AXI_RID, S_AXI_RLAST, S_AXI_RRESP} =
        S_AXI_RVALID ? r_mem_q[r_rp_q] : '0;

    assign ar_push  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_pop   = (state_q == ST_IDLE) && (ar_cnt_q != '0);
    assign req_fire = USR_REQ_VALID && USR_REQ_READY;
    assign rsp_fire = USR_RSP_VALID;
    assign r_pop    = S_AXI_RVALID && S_AXI_RREADY;

    assign {h_id, h_len, h_size, h_burst, h_addr} = ar_mem_q[ar_rp_q];
    assign h_wrap_bytes = (16'(h_len) + 16'd1) << h_size;
    assign h_beat_bytes = ADDR_WIDTH'(1) << h_size;
    assign h_wrap_mask  = ADDR_WIDTH'(h_wrap_bytes - 16'd1);
    assign h_wrap_ok    = (h_len == 8'd1) || (h_len == 8'd3) || (h_len == 8'd7) || (h_len == 8'd15);

    // FIXED, INCR and WRAP share one update: incr_q=0 freezes, mask_q='1 is plain INCR.
    assign next_addr = (addr_q & ~mask_q) | ((addr_q + incr_q) & mask_q);

    always_comb begin
        ar_mem_d  = ar_mem_q;
        ar_wp_d   = ar_wp_q;
        ar_rp_d   = ar_rp_q;
        ar_cnt_d  = ar_cnt_q;
        tag_mem_d = tag_mem_q;
        tag_wp_d  = tag_wp_q;
        tag_rp_d  = tag_rp_q;
        r_mem_d   = r_mem_q;
        r_wp_d    = r_wp_q;
        r_rp_d    = r_rp_q;
        r_cnt_d   = r_cnt_q;
        outst_d   = outst_q;
        state_d   = state_q;
        addr_d    = addr_q;
        incr_d    = incr_q;
        mask_d    = mask_q;
        beats_d   = beats_q;
        id_d      = id_q;
        err_d     = err_q;

        if (ar_push) begin
            ar_mem_d[ar_wp_q] = {S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARADDR};
            ar_wp_d = ar_ptr_inc(ar_wp_q);
        end
        if (ar_pop) begin
            ar_rp_d = ar_ptr_inc(ar_rp_q);
        end
        case ({ar_push, ar_pop})
            2'b10:   ar_cnt_d = ar_cnt_q + AR_CW'(1);
            2'b01:   ar_cnt_d = ar_cnt_q - AR_CW'(1);
            default: ar_cnt_d = ar_cnt_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (ar_pop) begin
                    state_d = ST_ISSUE;
                    addr_d  = h_addr;
                    beats_d = h_len;
                    id_d    = h_id;
                    err_d   = (h_burst == 2'b11) || ((h_burst == 2'b10) && !h_wrap_ok) ||
                              (h_size > MAX_SIZE);
                    case (h_burst)
                        2'b01: begin
                            incr_d = h_beat_bytes;
                            mask_d = '1;
                        end
                        2'b10: begin
                            incr_d = h_beat_bytes;
                            mask_d = h_wrap_ok ? h_wrap_mask : '1;
                        end
                        default: begin
                            incr_d = '0;
                            mask_d = '1;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (req_fire) begin
                    if (beats_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beats_d = beats_q - 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (req_fire) begin
            tag_mem_d[tag_wp_q] = {id_q, (beats_q == 8'd0), (err_q ? 2'b10 : 2'b00)};
            tag_wp_d = rs_ptr_inc(tag_wp_q);
        end
        if (rsp_fire) begin
            r_mem_d[r_wp_q] = {USR_RSP_DATA, tag_mem_q[tag_rp_q]};
            r_wp_d   = rs_ptr_inc(r_wp_q);
            tag_rp_d = rs_ptr_inc(tag_rp_q);
        end
        if (r_pop) begin
            r_rp_d = rs_ptr_inc(r_rp_q);
        end
        case ({rsp_fire, r_pop})
            2'b10:   r_cnt_d = r_cnt_q + RS_CW'(1);
            2'b01:   r_cnt_d = r_cnt_q - RS_CW'(1);
            default: r_cnt_d = r_cnt_q;
        endcase
        // Outstanding spans request through R handshake, so both FIFOs are bounded by it.
        case ({req_fire, r_pop})
            2'b10:   outst_d = outst_q + RS_CW'(1);
            2'b01:   outst_d = outst_q - RS_CW'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ar_mem_q  <= '{default: '0};
            ar_wp_q   <= '0;
            ar_rp_q   <= '0;
            ar_cnt_q  <= '0;
            tag_mem_q <= '{default: '0};
            tag_wp_q  <= '0;
            tag_rp_q  <= '0;
            r_mem_q   <= '{default: '0};
            r_wp_q    <= '0;
            r_rp_q    <= '0;
            r_cnt_q   <= '0;
            outst_q   <= '0;
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            incr_q    <= '0;
            mask_q    <= '0;
            beats_q   <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            ar_mem_q  <= ar_mem_d;
            ar_wp_q   <= ar_wp_d;
            ar_rp_q   <= ar_rp_d;
            ar_cnt_q  <= ar_cnt_d;
            tag_mem_q <= tag_mem_d;
            tag_wp_q  <= tag_wp_d;
            tag_rp_q  <= tag_rp_d;
            r_mem_q   <= r_mem_d;
            r_wp_q    <= r_wp_d;
            r_rp_q    <= r_rp_d;
            r_cnt_q   <= r_cnt_d;
            outst_q   <= outst_d;
            state_q   <= state_d;
            addr_q    <= addr_d;
            incr_q    <= incr_d;
            mask_q    <= mask_d;
            beats_q   <= beats_d;
            id_q      <= id_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_s_axi_burst_read_bridge.sv
// Directed bench for s_axi_burst_read_bridge: a one-cycle-latency user memory
// returns {16'hC0DE, 8'h5A, addr}, and R beats are compared with hand-derived values.
module tb_s_axi_burst_read_bridge;

    logic        clk;
    logic        rst;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [7:0]  req_addr;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t     r_log[$];
    logic [7:0] req_log[$];
    int         req_cyc[$];
    logic [7:0] exp_a[$];
    int         cyc;
    int         n_cmp;
    int         n_err;

    s_axi_burst_read_bridge #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .ID_WIDTH  (4),
        .AR_DEPTH  (4),
        .RSP_DEPTH (8)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARLEN  (arlen),
        .S_AXI_ARSIZE (arsize),
        .S_AXI_ARBURST(arburst),
        .S_AXI_ARID   (arid),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RID    (rid),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RLAST  (rlast),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .USR_REQ_ADDR (req_addr),
        .USR_REQ_VALID(req_valid),
        .USR_REQ_READY(req_ready),
        .USR_RSP_DATA (rsp_data),
        .USR_RSP_VALID(rsp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {16'hC0DE, 8'h5A, a};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // User memory model and handshake monitor; requests are observed mid-cycle.
    initial begin
        logic       fire;
        logic [7:0] a;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && rvalid && rready)
                r_log.push_back('{data: rdata, id: rid, resp: rresp, last: rlast});
            fire = !rst && req_valid && req_ready;
            a    = req_addr;
            if (fire) begin
                req_log.push_back(a);
                req_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
            rsp_valid = fire;
            rsp_data  = fire ? mem_word(a) : '0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic clear_logs();
        r_log.delete();
        req_log.delete();
        req_cyc.delete();
    endtask

    task automatic send_ar(input logic [7:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        logic ok;
        araddr  = a;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arid    = id;
        arvalid = 1'b1;
        ok      = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (arready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        check_eq("ar_accept", 64'(ok), 64'(1));
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int k = 0; k < 200 && r_log.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_nbeats"}, 64'(r_log.size()), 64'(n));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_burst(input string tag, input logic [3:0] id, input logic [1:0] resp);
        check_eq({tag, "_nreq"}, 64'(req_log.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < req_log.size())
                check_eq($sformatf("%s_addr%0d", tag, i), 64'(req_log[i]), 64'(exp_a[i]));
            if (i < r_log.size()) begin
                check_eq($sformatf("%s_data%0d", tag, i), 64'(r_log[i].data), 64'(mem_word(exp_a[i])));
                check_eq($sformatf("%s_rid%0d", tag, i), 64'(r_log[i].id), 64'(id));
                check_eq($sformatf("%s_resp%0d", tag, i), 64'(r_log[i].resp), 64'(resp));
                check_eq($sformatf("%s_last%0d", tag, i), 64'(r_log[i].last),
                         64'(i == exp_a.size() - 1));
            end
        end
    endtask

    initial begin
        logic seen;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        arid      = '0;
        arvalid   = 1'b0;
        rready    = 1'b1;
        req_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_arready", 64'(arready), 64'(0));
        check_eq("rst_rvalid", 64'(rvalid), 64'(0));
        check_eq("rst_reqvalid", 64'(req_valid), 64'(0));
        check_eq("rst_rlast", 64'(rlast), 64'(0));
        check_eq("rst_rresp", 64'(rresp), 64'(0));
        check_eq("rst_rid", 64'(rid), 64'(0));
        check_eq("rst_rdata", 64'(rdata), 64'(0));
        check_eq("rst_reqaddr", 64'(req_addr), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_arready", 64'(arready), 64'(1));

        // INCR with request latency: handshake cycle N, request valid in N+2
        clear_logs();
        send_ar(8'h10, 8'd3, 3'd2, 2'b01, 4'd5);
        check_eq("lat_n1", 64'(req_valid), 64'(0));
        @(posedge clk);
        #1;
        check_eq("lat_n2", 64'(req_valid), 64'(1));
        check_eq("lat_n2_addr", 64'(req_addr), 64'(8'h10));
        wait_beats("incr", 4);
        exp_a = '{8'h10, 8'h14, 8'h18, 8'h1C};
        check_burst("incr", 4'd5, 2'b00);

        clear_logs();
        send_ar(8'h38, 8'd3, 3'd2, 2'b10, 4'd2);
        wait_beats("wrap", 4);
        exp_a = '{8'h38, 8'h3C, 8'h30, 8'h34};
        check_burst("wrap", 4'd2, 2'b00);

        clear_logs();
        send_ar(8'h20, 8'd1, 3'd2, 2'b11, 4'd7);
        wait_beats("rsvd", 2);
        exp_a = '{8'h20, 8'h20};
        check_burst("rsvd", 4'd7, 2'b10);

        clear_logs();
        send_ar(8'h40, 8'd2, 3'd2, 2'b10, 4'd6);
        wait_beats("badwrap", 3);
        exp_a = '{8'h40, 8'h44, 8'h48};
        check_burst("badwrap", 4'd6, 2'b10);

        clear_logs();
        send_ar(8'h08, 8'd0, 3'd3, 2'b01, 4'd1);
        wait_beats("bigsize", 1);
        exp_a = '{8'h08};
        check_burst("bigsize", 4'd1, 2'b10);

        clear_logs();
        send_ar(8'hF8, 8'd2, 3'd2, 2'b01, 4'd4);
        wait_beats("addrwrap", 3);
        exp_a = '{8'hF8, 8'hFC, 8'h00};
        check_burst("addrwrap", 4'd4, 2'b00);

        // Queue full: the FSM holds one burst, so AR_DEPTH+1 are taken before ARREADY drops
        clear_logs();
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_ar(8'h40 + 8'(4 * i), 8'd0, 3'd2, 2'b01, 4'(i));
        araddr  = 8'h54;
        arid    = 4'd5;
        arvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("full_arready%0d", k), 64'(arready), 64'(0));
            @(posedge clk);
            #1;
        end
        req_ready = 1'b1;
        begin
            logic ok;
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                if (arready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            arvalid = 1'b0;
            check_eq("full_sixth_accept", 64'(ok), 64'(1));
        end
        wait_beats("full", 6);
        check_eq("full_nreq", 64'(req_log.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < req_log.size())
                check_eq($sformatf("full_addr%0d", i), 64'(req_log[i]), 64'(8'h40 + 8'(4 * i)));
            if (i < r_log.size())
                check_eq($sformatf("full_rid%0d", i), 64'(r_log[i].id), 64'(i));
            if (i > 0 && i < req_cyc.size())
                check_eq($sformatf("full_gap%0d", i), 64'(req_cyc[i] - req_cyc[i-1]), 64'(2));
        end

        // Backpressure: only RSP_DEPTH requests may be outstanding
        clear_logs();
        rready = 1'b0;
        send_ar(8'h00, 8'd15, 3'd2, 2'b01, 4'd3);
        repeat (40) @(posedge clk);
        #1;
        check_eq("bp_nreq", 64'(req_log.size()), 64'(8));
        check_eq("bp_reqvalid", 64'(req_valid), 64'(0));
        check_eq("bp_rvalid", 64'(rvalid), 64'(1));
        check_eq("bp_rdata", 64'(rdata), 64'(mem_word(8'h00)));
        check_eq("bp_rlast", 64'(rlast), 64'(0));
        @(posedge clk);
        #1;
        check_eq("bp_rdata_stable", 64'(rdata), 64'(mem_word(8'h00)));
        rready = 1'b1;
        wait_beats("bp", 16);
        exp_a.delete();
        for (int i = 0; i < 16; i++) exp_a.push_back(8'(4 * i));
        check_burst("bp", 4'd3, 2'b00);

        // Reset after the second beat of an 8-beat burst
        clear_logs();
        send_ar(8'h00, 8'd7, 3'd2, 2'b01, 4'd8);
        for (int k = 0; k < 50 && req_log.size() < 2; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq("mid_reached", 64'(req_log.size()), 64'(2));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rvalid", 64'(rvalid), 64'(0));
        check_eq("mid_reqvalid", 64'(req_valid), 64'(0));
        check_eq("mid_arready", 64'(arready), 64'(0));
        check_eq("mid_rlast", 64'(rlast), 64'(0));
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            seen = seen | req_valid | rvalid;
        end
        check_eq("mid_quiet", 64'(seen), 64'(0));
        check_eq("mid_arready_back", 64'(arready), 64'(1));

        clear_logs();
        send_ar(8'h80, 8'd1, 3'd2, 2'b01, 4'd9);
        wait_beats("after", 2);
        exp_a = '{8'h80, 8'h84};
        check_burst("after", 4'd9, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
